// File: rtl/timer_ctrl.sv
// Countdown timer controller: loads a start value, gates the time converter
// and counts its ticks down to a one-cycle done pulse, with pause/resume/clear.
module timer_ctrl #(
  parameter int W           = 16,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic         pause,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         conv_en,
  output logic [W-1:0] count,
  output logic         running,
  output logic         paused,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t       state, state_n;
  logic [W-1:0] count_n;
  logic         tick_d;
  logic         tick_ev;
  logic         load_zero;
  logic         running_n, paused_n, done_n, conv_en_n;

  // A tick held high for several cycles must only count once.
  assign tick_ev   = tick & ~tick_d;
  assign load_zero = (load_val == '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      count   <= '0;
      tick_d  <= 1'b0;
      running <= 1'b0;
      paused  <= 1'b0;
      done    <= 1'b0;
      conv_en <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      tick_d  <= tick;
      running <= running_n;
      paused  <= paused_n;
      done    <= done_n;
      conv_en <= conv_en_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    if (clear) begin
      state_n = IDLE;
      count_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (load_zero) begin
              state_n = DONE;
            end else begin
              state_n = RUN;
              count_n = load_val;
            end
          end
        end
        RUN: begin
          // The final decrement wins over a simultaneous pause.
          if (tick_ev && count <= W'(1)) begin
            state_n = DONE;
            count_n = '0;
          end else begin
            if (tick_ev) begin
              count_n = count - W'(1);
            end
            if (pause) begin
              state_n = PAUSED;
            end
          end
        end
        PAUSED: begin
          if (start && !pause) begin
            state_n = RUN;
          end
        end
        DONE: begin
          if (AUTO_RELOAD && !load_zero) begin
            state_n = RUN;
            count_n = load_val;
          end else begin
            state_n = IDLE;
            count_n = '0;
          end
        end
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end
  end

  // Flags are registered from the next state so they change with the state register.
  always_comb begin
    running_n = (state_n == RUN);
    paused_n  = (state_n == PAUSED);
    done_n    = (state_n == DONE);
    conv_en_n = (state_n == RUN);
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed testbench for timer_ctrl: vector table plus hand-written corner sequences,
// with one instance in stop-at-expiry mode and one in auto-reload mode.
module tb_timer_ctrl;

  localparam int W = 16;

  logic         clk;
  logic         rst_b;
  logic         start, pause, clear, tick;
  logic [W-1:0] load_val;

  logic         conv_en0, running0, paused0, done0;
  logic [W-1:0] count0;
  logic         conv_en1, running1, paused1, done1;
  logic [W-1:0] count1;

  int errors = 0;
  int checks = 0;

  timer_ctrl #(.W(W), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst_b(rst_b), .start(start), .pause(pause), .clear(clear),
    .load_val(load_val), .tick(tick), .conv_en(conv_en0), .count(count0),
    .running(running0), .paused(paused0), .done(done0)
  );

  timer_ctrl #(.W(W), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst_b(rst_b), .start(start), .pause(pause), .clear(clear),
    .load_val(load_val), .tick(tick), .conv_en(conv_en1), .count(count1),
    .running(running1), .paused(paused1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         st, pa, cl, tk;
    logic [W-1:0] lv;
    logic [W-1:0] e_count;
    logic         e_run, e_pau, e_done;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic st, pa, cl, tk, input int lv,
                              input int ec, input logic er, ep, ed);
    vec_t v;
    v.st = st; v.pa = pa; v.cl = cl; v.tk = tk;
    v.lv = W'(lv); v.e_count = W'(ec);
    v.e_run = er; v.e_pau = ep; v.e_done = ed;
    return v;
  endfunction

  // Packed view: {count, running, paused, done, conv_en}
  function automatic logic [W+3:0] exp_pk(input int c, input logic r, p, d);
    return {W'(c), r, p, d, r};
  endfunction

  function automatic logic [W+3:0] act0();
    return {count0, running0, paused0, done0, conv_en0};
  endfunction

  function automatic logic [W+3:0] act1();
    return {count1, running1, paused1, done1, conv_en1};
  endfunction

  task automatic apply_stimulus(input logic st, pa, cl, tk, input int lv);
    @(negedge clk);
    start = st; pause = pa; clear = cl; tick = tk; load_val = W'(lv);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [W+3:0] act,
                              input logic [W+3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got count=%0d run=%b pau=%b done=%b en=%b, want count=%0d run=%b pau=%b done=%b en=%b",
               name, act[W+3:4], act[3], act[2], act[1], act[0],
               exp[W+3:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    // Stop-at-expiry vectors: {start, pause, clear, tick, load_val} -> {count, run, paused, done}
    vecs[0]  = mk(1, 0, 0, 0, 4, 4, 1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 4, 4, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 4, 3, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 4, 3, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 4, 2, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 4, 2, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 4, 2, 1, 0, 0);
    vecs[7]  = mk(0, 1, 0, 0, 4, 2, 0, 1, 0);
    vecs[8]  = mk(0, 0, 0, 1, 4, 2, 0, 1, 0);
    vecs[9]  = mk(1, 1, 0, 0, 4, 2, 0, 1, 0);
    vecs[10] = mk(1, 0, 0, 0, 4, 2, 1, 0, 0);
    vecs[11] = mk(1, 0, 0, 1, 4, 1, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 4, 1, 1, 0, 0);
    vecs[13] = mk(0, 1, 0, 1, 0, 0, 0, 0, 1);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[17] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, 0, 0, 0, 3, 3, 1, 0, 0);
    vecs[20] = mk(0, 0, 1, 1, 3, 0, 0, 0, 0);
    vecs[21] = mk(1, 0, 0, 0, 3, 3, 1, 0, 0);
    vecs[22] = mk(0, 1, 0, 1, 3, 2, 0, 1, 0);
    vecs[23] = mk(0, 0, 1, 0, 3, 0, 0, 0, 0);

    rst_b = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; tick = 1'b0; load_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset0", act0(), exp_pk(0, 0, 0, 0));
    check_output("reset1", act1(), exp_pk(0, 0, 0, 0));
    @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < 24; i++) begin
      apply_stimulus(vecs[i].st, vecs[i].pa, vecs[i].cl, vecs[i].tk, int'(vecs[i].lv));
      check_output($sformatf("vec%0d", i), act0(),
                   exp_pk(int'(vecs[i].e_count), vecs[i].e_run, vecs[i].e_pau, vecs[i].e_done));
    end

    // Reset asserted mid-count aborts asynchronously
    apply_stimulus(1, 0, 0, 0, 5);
    apply_stimulus(0, 0, 0, 1, 5);
    apply_stimulus(0, 0, 0, 0, 5);
    apply_stimulus(0, 0, 0, 1, 5);
    apply_stimulus(0, 0, 0, 0, 5);
    check_output("pre_reset", act0(), exp_pk(3, 1, 0, 0));
    #2 rst_b = 1'b0;
    #1;
    check_output("async_reset", act0(), exp_pk(0, 0, 0, 0));
    @(negedge clk);
    rst_b = 1'b1;
    apply_stimulus(1, 0, 0, 0, 3);
    check_output("restart", act0(), exp_pk(3, 1, 0, 0));
    apply_stimulus(0, 0, 1, 0, 3);

    // Basic countdown with widely spaced ticks; done must appear exactly once
    apply_stimulus(1, 0, 0, 0, 4);
    check_output("cd_start", act0(), exp_pk(4, 1, 0, 0));
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, 0, 1, 4);
      if (i < 3) check_output($sformatf("cd_tick%0d", i), act0(), exp_pk(3 - i, 1, 0, 0));
      else       check_output("cd_final", act0(), exp_pk(0, 0, 0, 1));
      for (int j = 0; j < 9; j++) begin
        apply_stimulus(0, 0, 0, 0, 4);
        if (i < 3) check_output($sformatf("cd_gap%0d_%0d", i, j), act0(), exp_pk(3 - i, 1, 0, 0));
        else       check_output($sformatf("cd_idle%0d", j), act0(), exp_pk(0, 0, 0, 0));
      end
    end

    // Pause and resume
    apply_stimulus(1, 0, 0, 0, 6);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(0, 0, 0, 1, 6);
      apply_stimulus(0, 0, 0, 0, 6);
    end
    apply_stimulus(0, 1, 0, 0, 6);
    check_output("pr_paused", act0(), exp_pk(4, 0, 1, 0));
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, 1, 6);
      apply_stimulus(0, 0, 0, 0, 6);
      check_output($sformatf("pr_hold%0d", i), act0(), exp_pk(4, 0, 1, 0));
    end
    apply_stimulus(1, 0, 0, 0, 6);
    check_output("pr_resume", act0(), exp_pk(4, 1, 0, 0));
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, 0, 1, 6);
      if (i < 3) check_output($sformatf("pr_tick%0d", i), act0(), exp_pk(3 - i, 1, 0, 0));
      else       check_output("pr_done", act0(), exp_pk(0, 0, 0, 1));
      apply_stimulus(0, 0, 0, 0, 6);
    end
    check_output("pr_idle", act0(), exp_pk(0, 0, 0, 0));

    // Tick held high for five cycles counts once
    apply_stimulus(1, 0, 0, 0, 3);
    repeat (5) apply_stimulus(0, 0, 0, 1, 3);
    apply_stimulus(0, 0, 0, 0, 3);
    check_output("held_tick", act0(), exp_pk(2, 1, 0, 0));
    apply_stimulus(0, 0, 1, 0, 3);

    // Auto-reload: three periods of two ticks, running drops only in the done cycle
    apply_stimulus(1, 0, 0, 0, 2);
    check_output("ar_start", act1(), exp_pk(2, 1, 0, 0));
    for (int p = 0; p < 3; p++) begin
      apply_stimulus(0, 0, 0, 1, 2);
      check_output($sformatf("ar_t1_%0d", p), act1(), exp_pk(1, 1, 0, 0));
      apply_stimulus(0, 0, 0, 0, 2);
      check_output($sformatf("ar_g1_%0d", p), act1(), exp_pk(1, 1, 0, 0));
      apply_stimulus(0, 0, 0, 1, 2);
      check_output($sformatf("ar_done_%0d", p), act1(), exp_pk(0, 0, 0, 1));
      apply_stimulus(0, 0, 0, 0, 2);
      check_output($sformatf("ar_reload_%0d", p), act1(), exp_pk(2, 1, 0, 0));
    end
    apply_stimulus(0, 0, 0, 1, 2);
    apply_stimulus(0, 0, 1, 0, 2);
    check_output("ar_clear", act1(), exp_pk(0, 0, 0, 0));
    apply_stimulus(0, 0, 0, 0, 2);
    check_output("ar_clear_hold", act1(), exp_pk(0, 0, 0, 0));

    // Zero load goes straight to done and back to idle, even with auto-reload
    apply_stimulus(1, 0, 0, 0, 0);
    check_output("zero_done0", act0(), exp_pk(0, 0, 0, 1));
    check_output("zero_done1", act1(), exp_pk(0, 0, 0, 1));
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("zero_idle0", act0(), exp_pk(0, 0, 0, 0));
    check_output("zero_idle1", act1(), exp_pk(0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Countdown timer controller that sequences the tick-generating time converter.
- Loads a start value, gates the converter's enable, and decrements the count on each converter tick.
- Supports pause, resume, clear and an optional periodic auto-reload; signals expiry with a one-cycle done pulse.
- Sits between the user/control interface and the time converter. Tick unit (ms or s) is set by the converter's CLOCK_FREQ.

Parameters:
- W, 16, width of load value and count.
- AUTO_RELOAD, 0, 1 = on expiry reload load_val and keep running; 0 = stop at expiry.

Ports:
- clk  input  1  system clock
- rst_b  input  1  asynchronous active-low reset
- start  input  1  start from IDLE, or resume from PAUSED; single-cycle or level
- pause  input  1  pause a running countdown
- clear  input  1  abort to IDLE and zero the count
- load_val  input  W  initial/reload count, sampled on accepted start and on reload
- tick  input  1  time-converter output (clk_conv)
- conv_en  output  1  enable to the time converter; high only while RUN
- count  output  W  remaining ticks
- running  output  1  state == RUN
- paused  output  1  state == PAUSED
- done  output  1  one-cycle pulse on expiry

Behaviour:
- Reset is asynchronous, active-low.
  - Reset values: state = IDLE, count = 0, conv_en = 0, running = 0, paused = 0, done = 0, tick_d = 0.
  - Reset asserted mid-count aborts immediately. No done pulse is produced.
- Tick event is tick & ~tick_d, where tick_d is tick registered on clk. A tick held high for N cycles counts once.
- All outputs are registered. Flags follow state in the same cycle the state register updates.
- States: IDLE, RUN, PAUSED, DONE.
- IDLE:
  - start with load_val != 0 → count <= load_val, go to RUN.
  - start with load_val == 0 → go to DONE directly (count stays 0).
  - Tick events are ignored.
- RUN:
  - conv_en = 1.
  - On a tick event, count <= count − 1.
  - When a tick event occurs with count == 1: count <= 0, go to DONE.
  - Count never wraps below 0.
- PAUSED:
  - conv_en = 0, so the converter restarts its period on resume.
  - count is held and tick events are ignored.
  - start → RUN.
- DONE (one cycle):
  - done = 1 and conv_en = 0.
  - AUTO_RELOAD = 0 → go to IDLE with count = 0.
  - AUTO_RELOAD = 1 and load_val != 0 → count <= load_val, go to RUN.
  - AUTO_RELOAD = 1 and load_val == 0 → go to IDLE.
- Priority within a cycle: clear > tick decrement > pause > start.
  - clear in any state → IDLE, count <= 0, no done pulse.
  - Tick event and pause in the same RUN cycle: decrement applies, then PAUSED. If that decrement reaches 0, DONE takes precedence over PAUSED.
  - start while in RUN or DONE is ignored. pause while in IDLE, PAUSED or DONE is ignored.
  - start and pause together in PAUSED: stays PAUSED.
- Latency:
  - Accepted start → running = 1 and conv_en = 1 on the next clk edge.
  - Final tick edge → done = 1 on the next clk edge, for exactly one cycle.

Test Plan:
- Reset mid-run: load_val = 5, start, release rst_b low after 2 ticks → all outputs 0 immediately. Then start with load_val = 3 → running = 1 after 1 cycle, count = 3.
- Basic countdown: load_val = 4, start, 4 one-cycle ticks spaced 10 cycles apart → count steps 3, 2, 1, 0. done pulses exactly once, 1 cycle after the 4th tick. Then IDLE with running = 0 and conv_en = 0.
- Pause/resume: load_val = 6, 2 ticks, pause → paused = 1, conv_en = 0, count = 4 held across 3 injected ticks. start → RUN, and 4 more ticks → done.
- Edge cases:
  - A tick held high for 5 cycles decrements count by 1 only.
  - Tick and pause in the same cycle with count = 3 → count = 2, PAUSED.
  - Same with count = 1 → done, not PAUSED.
- Auto-reload (AUTO_RELOAD = 1): load_val = 2 → done pulses every 2 ticks across 3 periods, with running continuously 1 except the DONE cycle. clear → IDLE, count = 0, no done.
- Zero load: start with load_val = 0 → done pulse the cycle after start, then IDLE. With AUTO_RELOAD = 1 it still returns to IDLE.
